// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring integer divider with early special-case exit
//
// Purpose: divides a by b, one quotient bit per clock. Signed/unsigned and
// full-width/word operation. Returns either the quotient or the remainder.
//
// Parameters:
//   WIDTH          datapath width (even, >= 8)
//   EARLY_SPECIAL  1: divide-by-zero and signed overflow finish one cycle after accept
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   in_valid/ready  request handshake (in_ready high only when idle)
//   a, b            dividend, divisor
//   is_signed       two's-complement operands
//   is_word         operate on the low WIDTH/2 bits; the result is sign-extended
//   want_rem        return the remainder instead of the quotient
//   flush           abandon any operation in flight or waiting to be collected
//   out_valid/ready result handshake
//   result          quotient or remainder; zero while out_valid is low
module div_unit #(
    parameter int WIDTH         = 64,
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             is_word,
    input  logic             want_rem,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [HALF-1:0]  MIN_H = {1'b1, {(HALF-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0] quo, rem, dvs, spec_val_r;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, rem_sel, word_r, spec_r;

    logic accept;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~flush;

    // Operand preparation, evaluated on the input ports at the accept edge.
    logic [WIDTH-1:0] a_sx, a_ext, b_ext, a_mag, b_mag, spec_val;
    logic             a_neg, b_neg, div0, ovf, special;

    always_comb begin
        // a_sx is the dividend as an N-bit value sign-extended to WIDTH; it is
        // what the special cases return, independent of is_signed.
        a_sx  = is_word ? {{HALF{a[HALF-1]}}, a[HALF-1:0]} : a;
        a_ext = (is_word & ~is_signed) ? {{HALF{1'b0}}, a[HALF-1:0]} : a_sx;
        b_ext = is_word ? (is_signed ? {{HALF{b[HALF-1]}}, b[HALF-1:0]}
                                     : {{HALF{1'b0}}, b[HALF-1:0]}) : b;
        a_neg = is_signed & a_ext[WIDTH-1];
        b_neg = is_signed & b_ext[WIDTH-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        div0  = is_word ? (b[HALF-1:0] == '0) : (b == '0);
        ovf   = is_signed & (is_word ? ((a[HALF-1:0] == MIN_H) && (&b[HALF-1:0]))
                                     : ((a == MIN_W) && (&b)));
        special = div0 | ovf;
        if (want_rem) spec_val = div0 ? a_sx : '0;
        else          spec_val = div0 ? '1   : a_sx;
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The dividend is kept
    // left-aligned in quo so word mode shifts from the same position.
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff, rem_nx, quo_nx;
    logic             ge;

    always_comb begin
        sh     = {rem, quo[WIDTH-1]};
        ge     = (sh >= {1'b0, dvs});
        diff   = sh[WIDTH-1:0] - dvs;
        rem_nx = ge ? diff : sh[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ge};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = (special && EARLY_SPECIAL) ? DONE : BUSY;
            BUSY: if (cnt <= CW'(1)) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            cnt        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            rem_sel    <= 1'b0;
            word_r     <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= '0;
        end else if (accept) begin
            quo        <= is_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
            rem        <= '0;
            dvs        <= b_mag;
            cnt        <= is_word ? CW'(HALF) : CW'(WIDTH);
            neg_q      <= a_neg ^ b_neg;
            neg_r      <= a_neg;
            rem_sel    <= want_rem;
            word_r     <= is_word;
            spec_r     <= special;
            spec_val_r <= spec_val;
        end else if (state == BUSY && cnt != '0) begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt - CW'(1);
        end
    end

    // Result is formed from held registers, so it stays stable under backpressure.
    logic [WIDTH-1:0] q_s, r_s, sel, fin;

    always_comb begin
        q_s = neg_q ? -quo : quo;
        r_s = neg_r ? -rem : rem;
        sel = rem_sel ? r_s : q_s;
        fin = word_r ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
        if (spec_r) fin = spec_val_r;
        result = out_valid ? fin : '0;
    end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector bench for div_unit
module tb_div_unit;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [W-1:0] a, b;
    logic         is_signed, is_word, want_rem, flush;
    logic         iv0, iv1, or0, or1;
    logic         ir0, ir1, ov0, ov1;
    logic [W-1:0] res0, res1;

    int n_cmp  = 0;
    int n_fail = 0;

    // dut: early special-case exit; dut_slow: special cases take the full path
    div_unit #(.WIDTH(W), .EARLY_SPECIAL(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0),
        .a(a), .b(b), .is_signed(is_signed), .is_word(is_word), .want_rem(want_rem),
        .flush(flush), .out_valid(ov0), .out_ready(or0), .result(res0));

    div_unit #(.WIDTH(W), .EARLY_SPECIAL(1'b0)) dut_slow (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
        .a(a), .b(b), .is_signed(is_signed), .is_word(is_word), .want_rem(want_rem),
        .flush(flush), .out_valid(ov1), .out_ready(or1), .result(res1));

    typedef struct {
        int         sel;
        logic [63:0] a, b;
        logic       sg, wd, rm;
        logic [63:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic f_ir(input int s);
        return (s != 0) ? ir1 : ir0;
    endfunction
    function automatic logic f_ov(input int s);
        return (s != 0) ? ov1 : ov0;
    endfunction
    function automatic logic [63:0] f_res(input int s);
        return (s != 0) ? res1 : res0;
    endfunction

    task automatic set_iv(input int s, input logic v);
        if (s != 0) iv1 = v; else iv0 = v;
    endtask
    task automatic set_or(input int s, input logic v);
        if (s != 0) or1 = v; else or0 = v;
    endtask

    // Present a request one cycle, accept at the next rising edge; returns at
    // the negedge after the accept edge (latency count 1).
    task automatic apply(input int s, input logic [63:0] av, input logic [63:0] bv,
                         input logic sg, input logic wd, input logic rm);
        @(negedge clk);
        a = av; b = bv; is_signed = sg; is_word = wd; want_rem = rm;
        check("in_ready_before_accept", {63'd0, f_ir(s)}, 64'd1);
        set_iv(s, 1'b1);
        @(negedge clk);
        set_iv(s, 1'b0);
    endtask

    task automatic wait_valid(input int s, output int lat);
        logic nz;
        nz  = 1'b0;
        lat = 1;
        while (!f_ov(s) && lat < 200) begin
            if (f_res(s) !== 64'd0) nz = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("result_zero_while_invalid", {63'd0, nz}, 64'd0);
        if (lat >= 200) check("out_valid_timeout", 64'(lat), 64'd0);
    endtask

    task automatic consume(input int s);
        set_or(s, 1'b1);
        @(negedge clk);
        set_or(s, 1'b0);
        check("in_ready_after_consume", {63'd0, f_ir(s)}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        apply(v.sel, v.a, v.b, v.sg, v.wd, v.rm);
        wait_valid(v.sel, lat);
        check("result", f_res(v.sel), v.exp);
        check("latency", 64'(lat), 64'(v.lat));
        consume(v.sel);
    endtask

    initial begin
        int   lat;
        logic seen;
        vec_t v100;

        reset = 1'b0; a = '0; b = '0; is_signed = 0; is_word = 0; want_rem = 0;
        flush = 0; iv0 = 0; iv1 = 0; or0 = 0; or1 = 0;
        #2;
        check("reset_in_ready", {63'd0, ir0}, 64'd1);
        check("reset_out_valid", {63'd0, ov0}, 64'd0);
        check("reset_result", res0, 64'd0);
        check("reset_in_ready_slow", {63'd0, ir1}, 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        //           sel  a                       b                       sg wd rm  expected                lat
        vecs.push_back('{0, 64'd100,               64'd7,                  0, 0, 0, 64'd14,                 65});
        vecs.push_back('{0, 64'd100,               64'd7,                  0, 0, 1, 64'd2,                  65});
        vecs.push_back('{0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65});
        vecs.push_back('{0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65});
        vecs.push_back('{0, 64'h1234,              64'd0,                  0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
        vecs.push_back('{0, 64'h1234,              64'd0,                  0, 0, 1, 64'h1234,               1});
        vecs.push_back('{1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF,        1, 1, 0, 64'hFFFF_FFFF_8000_0000, 33});
        vecs.push_back('{1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF,        1, 1, 1, 64'd0,                  33});
        vecs.push_back('{0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF,        1, 1, 0, 64'hFFFF_FFFF_8000_0000, 1});
        vecs.push_back('{0, 64'hDEAD_BEEF_0000_0064, 64'hFFFF_0000_0000_0007, 0, 1, 0, 64'd14,              33});
        vecs.push_back('{0, 64'h0000_0000_FFFF_FFFF, 64'd1,                0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 33});
        vecs.push_back('{0, 64'd100,               64'hFFFF_FFFF_FFFF_FFF9, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF2, 65});
        vecs.push_back('{0, 64'd100,               64'hFFFF_FFFF_FFFF_FFF9, 1, 0, 1, 64'd2,                 65});
        vecs.push_back('{0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 64'h8000_0000_0000_0000, 1});
        vecs.push_back('{1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFB, 65});
        vecs.push_back('{1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 65});
        vecs.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,               0, 0, 0, 64'h0FFF_FFFF_FFFF_FFFF, 65});
        vecs.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,               0, 0, 1, 64'hF,                  65});
        vecs.push_back('{0, 64'h1234_5678_FFFF_FFF9, 64'd2,                1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFD, 33});
        vecs.push_back('{0, 64'h1234_5678_FFFF_FFF9, 64'd2,                1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 33});
        vecs.push_back('{0, 64'hAAAA_AAAA_1234_5678, 64'hFFFF_FFFF_0000_0000, 0, 1, 1, 64'h1234_5678,       1});
        vecs.push_back('{0, 64'hAAAA_AAAA_1234_5678, 64'hFFFF_FFFF_0000_0000, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1});

        foreach (vecs[i]) run_vec(vecs[i]);

        v100 = '{0, 64'd100, 64'd7, 0, 0, 0, 64'd14, 65};

        // Backpressure: result held, no new request taken while DONE.
        apply(0, 64'd100, 64'd7, 0, 0, 0);
        wait_valid(0, lat);
        for (int i = 0; i < 10; i++) begin
            check("bp_result", res0, 64'd14);
            check("bp_in_ready", {63'd0, ir0}, 64'd0);
            @(negedge clk);
        end
        check("bp_out_valid_held", {63'd0, ov0}, 64'd1);
        or0 = 1'b1;
        @(negedge clk);
        or0 = 1'b0;
        check("bp_release_in_ready", {63'd0, ir0}, 64'd1);
        check("bp_release_result", res0, 64'd0);

        // No accept in the same cycle DONE is left.
        apply(0, 64'd100, 64'd7, 0, 0, 0);
        wait_valid(0, lat);
        or0 = 1'b1; iv0 = 1'b1;
        @(negedge clk);
        or0 = 1'b0; iv0 = 1'b0;
        check("done_no_accept", {63'd0, ir0}, 64'd1);

        // flush together with out_ready in DONE.
        apply(0, 64'd100, 64'd7, 0, 0, 0);
        wait_valid(0, lat);
        flush = 1'b1; or0 = 1'b1;
        @(negedge clk);
        flush = 1'b0; or0 = 1'b0;
        check("flush_done_in_ready", {63'd0, ir0}, 64'd1);
        check("flush_done_out_valid", {63'd0, ov0}, 64'd0);

        // Flush at iteration 20.
        apply(0, 64'd100, 64'd7, 0, 0, 0);
        seen = 1'b0;
        repeat (19) begin
            if (ov0) seen = 1'b1;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_in_ready", {63'd0, ir0}, 64'd1);
        repeat (70) begin
            if (ov0) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_busy_never_valid", {63'd0, seen}, 64'd0);

        // A request presented with flush is not taken.
        a = 64'd100; b = 64'd7;
        flush = 1'b1; iv0 = 1'b1;
        @(negedge clk);
        flush = 1'b0; iv0 = 1'b0;
        check("flush_blocks_accept", {63'd0, ir0}, 64'd1);
        run_vec(v100);

        // Asynchronous reset at iteration 20.
        apply(0, 64'd100, 64'd7, 0, 0, 0);
        repeat (19) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("async_reset_in_ready", {63'd0, ir0}, 64'd1);
        check("async_reset_out_valid", {63'd0, ov0}, 64'd0);
        check("async_reset_result", res0, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (70) begin
            if (ov0) seen = 1'b1;
            @(negedge clk);
        end
        check("reset_busy_never_valid", {63'd0, seen}, 64'd0);
        run_vec(v100);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
